// File: rtl/proc_pkg.sv
// Shared pipeline types: mem-op encodings, register addresses, hazard states.
package proc_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam reg_addr_t REG_ZERO = 3'd0;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    BR_FLUSH
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam hz_ctrl_t CTRL_IDLE   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam hz_ctrl_t CTRL_SHADOW = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic logic branch_taken(
    input logic beq,
    input logic bne,
    input logic zero
  );
    return (beq & zero) | (bne & ~zero);
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Decode/execute hazard fields in, PC and IF/ID, ID/EX controls out.
// HAZARD_STATS_EN adds the stall/flush counter outputs.
interface hazard_flush_ctrl_if;
  import proc_pkg::*;

  reg_addr_t  id_rs;
  reg_addr_t  id_rt;
  logic       id_uses_rt;
  reg_addr_t  ex_rt;
  logic [1:0] ex_mem_op;
  logic       ex_beq;
  logic       ex_bne;
  logic       ex_zero;

  logic pc_write;
  logic pc_src;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt,
    output ex_mem_op, ex_beq, ex_bne, ex_zero,
    input  pc_write, pc_src, if_id_write,
    input  if_id_flush, id_ex_flush,
    input  stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt,
    input  ex_mem_op, ex_beq, ex_bne, ex_zero,
    output pc_write, pc_src, if_id_write,
    output if_id_flush, id_ex_flush,
    output stall_count, flush_count
  );
`else
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt,
    output ex_mem_op, ex_beq, ex_bne, ex_zero,
    input  pc_write, pc_src, if_id_write,
    input  if_id_flush, id_ex_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt,
    input  ex_mem_op, ex_beq, ex_bne, ex_zero,
    output pc_write, pc_src, if_id_write,
    output if_id_flush, id_ex_flush
  );
`endif

endinterface

// File: rtl/load_use_detect.sv
// Flags a decode source that matches the rt of a load sitting in execute.
module load_use_detect
  import proc_pkg::*;
(
  input  logic [1:0] ex_mem_op_i,
  input  reg_addr_t  ex_rt_i,
  input  reg_addr_t  id_rs_i,
  input  reg_addr_t  id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  logic is_load;
  logic rs_hit;
  logic rt_hit;

  assign is_load = (ex_mem_op_i == MEM_OP_LOAD)
                 && (ex_rt_i != REG_ZERO);
  assign rs_hit  = (ex_rt_i == id_rs_i);
  assign rt_hit  = id_uses_rt_i && (ex_rt_i == id_rt_i);

  assign load_use_o = is_load && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall and branch-shadow flush sequencer, updated on negedge clk.
// Define HAZARD_STATS_EN for saturating stall/flush counters.
module hazard_flush_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned BRANCH_SHADOW     = 1
) (
  input  logic                clk,
  input  logic                reset,
  hazard_flush_ctrl_if.slave  hz
);

  localparam logic [2:0] LS_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] BS_INIT = 3'(BRANCH_SHADOW - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  hz_ctrl_t   ctrl;
  logic       br_taken;
  logic       load_use;

  load_use_detect u_lud (
    .ex_mem_op_i  (hz.ex_mem_op),
    .ex_rt_i      (hz.ex_rt),
    .id_rs_i      (hz.id_rs),
    .id_rt_i      (hz.id_rt),
    .id_uses_rt_i (hz.id_uses_rt),
    .load_use_o   (load_use)
  );

  assign br_taken = branch_taken(hz.ex_beq, hz.ex_bne, hz.ex_zero);

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_IDLE;
    if (reset) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        RUN, LOAD_STALL: begin
          if (br_taken) begin
            ctrl = CTRL_BRANCH;
            if (BRANCH_SHADOW > 1) begin
              state_d = BR_FLUSH;
              cnt_d   = BS_INIT;
            end else begin
              state_d = RUN;
              cnt_d   = 3'd0;
            end
          end else if (state_q == LOAD_STALL) begin
            ctrl = CTRL_STALL;
            // cnt of 0 here is unreachable; fall back to RUN
            if (cnt_q <= 3'd1) begin
              state_d = RUN;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (load_use) begin
            ctrl = CTRL_STALL;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LS_INIT;
            end
          end
        end
        BR_FLUSH: begin
          ctrl = CTRL_SHADOW;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign hz.pc_write    = ctrl.pc_write;
  assign hz.pc_src      = ctrl.pc_src;
  assign hz.if_id_write = ctrl.if_id_write;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_flush = ctrl.id_ex_flush;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        br_flush;

  // only branch and shadow flushes keep the PC moving
  assign br_flush = ctrl.id_ex_flush & ctrl.pc_write;

  always_ff @(negedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!ctrl.pc_write && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (br_flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Drives three differently parameterised instances with shared stimulus
// and compares them against a cycle-count reference model.
module tb_hazard_flush_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r;
  logic [2:0] rs, rt, ert;
  logic       urt;
  logic [1:0] mop;
  logic       beq, bne, z;

  int lsc [3] = '{1, 3, 4};
  int bs  [3] = '{2, 1, 3};
  int sl  [3];
  int sh  [3];
  int msc [3];
  int mfc [3];

  int n_chk  = 0;
  int n_fail = 0;

  hazard_flush_ctrl_if if0 ();
  hazard_flush_ctrl_if if1 ();
  hazard_flush_ctrl_if if2 ();

  assign if0.id_rs = rs;  assign if1.id_rs = rs;  assign if2.id_rs = rs;
  assign if0.id_rt = rt;  assign if1.id_rt = rt;  assign if2.id_rt = rt;
  assign if0.id_uses_rt = urt;
  assign if1.id_uses_rt = urt;
  assign if2.id_uses_rt = urt;
  assign if0.ex_rt = ert; assign if1.ex_rt = ert; assign if2.ex_rt = ert;
  assign if0.ex_mem_op = mop;
  assign if1.ex_mem_op = mop;
  assign if2.ex_mem_op = mop;
  assign if0.ex_beq = beq; assign if1.ex_beq = beq; assign if2.ex_beq = beq;
  assign if0.ex_bne = bne; assign if1.ex_bne = bne; assign if2.ex_bne = bne;
  assign if0.ex_zero = z;  assign if1.ex_zero = z;  assign if2.ex_zero = z;

  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(1), .BRANCH_SHADOW(2))
    dut0 (.clk(clk), .reset(r), .hz(if0));
  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_SHADOW(1))
    dut1 (.clk(clk), .reset(r), .hz(if1));
  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(4), .BRANCH_SHADOW(3))
    dut2 (.clk(clk), .reset(r), .hz(if2));

  // {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush}
  logic [4:0] obs [3];
  assign obs[0] = {if0.pc_write, if0.pc_src, if0.if_id_write,
                   if0.if_id_flush, if0.id_ex_flush};
  assign obs[1] = {if1.pc_write, if1.pc_src, if1.if_id_write,
                   if1.if_id_flush, if1.id_ex_flush};
  assign obs[2] = {if2.pc_write, if2.pc_src, if2.if_id_write,
                   if2.if_id_flush, if2.id_ex_flush};

`ifdef HAZARD_STATS_EN
  logic [15:0] sc [3];
  logic [15:0] fc [3];
  assign sc[0] = if0.stall_count; assign fc[0] = if0.flush_count;
  assign sc[1] = if1.stall_count; assign fc[1] = if1.flush_count;
  assign sc[2] = if2.stall_count; assign fc[2] = if2.flush_count;
`endif

  localparam logic [4:0] O_RST   = 5'b00011;
  localparam logic [4:0] O_IDLE  = 5'b10100;
  localparam logic [4:0] O_BR    = 5'b11111;
  localparam logic [4:0] O_SHAD  = 5'b10111;
  localparam logic [4:0] O_STALL = 5'b00001;

  function automatic logic m_br();
    return (beq && z) || (bne && !z);
  endfunction

  function automatic logic m_lu();
    return mop == 2'b01 && ert != 3'd0 &&
           (ert == rs || (urt && ert == rt));
  endfunction

  // Outputs follow from remaining stall / shadow cycles plus live inputs.
  function automatic logic [4:0] model_out(int k);
    if (r) return O_RST;
    if (sh[k] > 0) return O_SHAD;
    if (m_br()) return O_BR;
    if (sl[k] > 0 || m_lu()) return O_STALL;
    return O_IDLE;
  endfunction

  task automatic apply(input logic rst, input logic [2:0] a_rs,
                       input logic [2:0] a_rt, input logic a_urt,
                       input logic [2:0] a_ert, input logic [1:0] a_mop,
                       input logic a_beq, input logic a_bne,
                       input logic a_z);
    @(posedge clk);
    r = rst; rs = a_rs; rt = a_rt; urt = a_urt;
    ert = a_ert; mop = a_mop; beq = a_beq; bne = a_bne; z = a_z;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [4:0] o;
      logic br, lu;
      o  = model_out(k);
      br = m_br();
      lu = m_lu();
      if (r) begin
        sl[k] = 0; sh[k] = 0; msc[k] = 0; mfc[k] = 0;
      end else begin
        if (!o[4] && msc[k] != 65535) msc[k]++;
        if ((sh[k] > 0 || br) && mfc[k] != 65535) mfc[k]++;
        if (sh[k] > 0) sh[k]--;
        else if (br) begin sh[k] = bs[k] - 1; sl[k] = 0; end
        else if (sl[k] > 0) sl[k]--;
        else if (lu) sl[k] = lsc[k] - 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== O_RST) begin
          n_fail++;
          $display("FAIL reset dut%0d got=%b want=%b", k, obs[k], O_RST);
        end
      end
      commit();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k] !== O_IDLE) begin
        n_fail++;
        $display("FAIL release dut%0d got=%b want=%b", k, obs[k], O_IDLE);
      end
    end
    commit();
  endtask

  task automatic settle();
    for (int c = 0; c < 6; c++) begin
      idle();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== model_out(k)) begin
          n_fail++;
          $display("FAIL settle dut%0d got=%b want=%b",
                   k, obs[k], model_out(k));
        end
      end
      commit();
    end
  endtask

  task automatic test_load_rs();
    apply(1'b0, 3'd3, 3'd0, 1'b0, 3'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (obs[0] !== O_STALL) begin
      n_fail++;
      $display("FAIL load_rs_stall got=%b want=%b", obs[0], O_STALL);
    end
    commit();
    idle();
    n_chk++;
    if (obs[0] !== O_IDLE) begin
      n_fail++;
      $display("FAIL load_rs_after got=%b want=%b", obs[0], O_IDLE);
    end
    commit();
    settle();
    apply(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k] !== O_IDLE) begin
        n_fail++;
        $display("FAIL load_r0 dut%0d got=%b want=%b", k, obs[k], O_IDLE);
      end
    end
    commit();
    settle();
  endtask

  task automatic test_load_rt();
    for (int c = 0; c < 4; c++) begin
      logic [4:0] w;
      if (c == 0)
        apply(1'b0, 3'd1, 3'd5, 1'b1, 3'd5, 2'b01, 1'b0, 1'b0, 1'b0);
      else
        idle();
      w = (c < 3) ? O_STALL : O_IDLE;
      n_chk++;
      if (obs[1] !== w) begin
        n_fail++;
        $display("FAIL load_rt c%0d got=%b want=%b", c, obs[1], w);
      end
      commit();
    end
    settle();
    apply(1'b0, 3'd1, 3'd5, 1'b0, 3'd5, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k] !== O_IDLE) begin
        n_fail++;
        $display("FAIL load_rt_unused dut%0d got=%b want=%b",
                 k, obs[k], O_IDLE);
      end
    end
    commit();
    settle();
  endtask

  task automatic test_branch();
    for (int c = 0; c < 3; c++) begin
      logic [4:0] w;
      if (c == 0)
        apply(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1);
      else
        idle();
      w = (c == 0) ? O_BR : (c == 1) ? O_SHAD : O_IDLE;
      n_chk++;
      if (obs[0] !== w) begin
        n_fail++;
        $display("FAIL beq c%0d got=%b want=%b", c, obs[0], w);
      end
      commit();
    end
    settle();
    apply(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k] !== O_IDLE) begin
        n_fail++;
        $display("FAIL bne_z dut%0d got=%b want=%b", k, obs[k], O_IDLE);
      end
    end
    commit();
    settle();
  endtask

  task automatic test_priority();
    apply(1'b0, 3'd2, 3'd0, 1'b0, 3'd2, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (obs[k] !== O_BR) begin
        n_fail++;
        $display("FAIL br_over_lu dut%0d got=%b want=%b", k, obs[k], O_BR);
      end
    end
    commit();
    settle();
  endtask

  task automatic test_reset_mid_stall();
    apply(1'b0, 3'd4, 3'd0, 1'b0, 3'd4, 2'b01, 1'b0, 1'b0, 1'b0);
    commit();
    idle();
    n_chk++;
    if (obs[2] !== O_STALL) begin
      n_fail++;
      $display("FAIL mid_stall got=%b want=%b", obs[2], O_STALL);
    end
    commit();
    apply(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    commit();
    idle();
    n_chk++;
    if (obs[2] !== O_IDLE) begin
      n_fail++;
      $display("FAIL after_rst got=%b want=%b", obs[2], O_IDLE);
    end
`ifdef HAZARD_STATS_EN
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (sc[k] !== 16'd0 || fc[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL stats_clr dut%0d got=%0d/%0d want=0/0",
                 k, sc[k], fc[k]);
      end
    end
`endif
    commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply($urandom_range(0, 39) == 0,
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== model_out(k)) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d got=%b want=%b",
                   c, k, obs[k], model_out(k));
        end
`ifdef HAZARD_STATS_EN
        n_chk++;
        if (sc[k] !== 16'(msc[k]) || fc[k] !== 16'(mfc[k])) begin
          n_fail++;
          $display("FAIL stats c%0d dut%0d got=%0d/%0d want=%0d/%0d",
                   c, k, sc[k], fc[k], msc[k], mfc[k]);
        end
`endif
      end
      commit();
    end
  endtask

  initial begin
    r = 1'b1; rs = '0; rt = '0; urt = 1'b0; ert = '0;
    mop = '0; beq = 1'b0; bne = 1'b0; z = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sl[k] = 0; sh[k] = 0; msc[k] = 0; mfc[k] = 0;
    end
    test_reset();
    test_load_rs();
    test_load_rt();
    test_branch();
    test_priority();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
